mc_main_ctrl: RTL
=================

# mc_main_ctrl

Main control FSM of the multi-cycle MIPS core: decodes the opcode latched in the instruction register and sequences the shared datapath (PC, unified memory, IR, register file, single ALU) through fetch/decode/execute/memory/writeback steps. Drives the 2-bit `ALUCtrlOp` consumed by the ALU decoder and all mux/write-enable selects. Stalls on a memory ready handshake and halts permanently on an illegal opcode.

## Interface
Parameters:
- none. All encodings are shared constants (see Structure).

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `PCWrite`  out  1  unconditional PC load.
- `PCWriteCond`  out  1  PC load if `zero`.
- `IorD`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `MemRead`  out  1  memory read request.
- `MemWrite`  out  1  memory write request.
- `IRWrite`  out  1  IR load.
- `MemtoReg`  out  1  RF write data: 0 = ALUOut, 1 = MDR.
- `RegDst`  out  1  RF write address: 0 = rt, 1 = rd.
- `RegWrite`  out  1  RF write enable.
- `ALUSrcA`  out  1  0 = PC, 1 = register A.
- `ALUSrcB`  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2.
- `PCSource`  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- `ALUCtrlOp`  out  2  ADD4=0, SUB=1, RTYPE=2, OR=3.
- `halted`  out  1  illegal opcode trapped.

## Operation
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, ori 001101; anything else is illegal.
- States (4-bit): FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, HALT.
- FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=1, ADD4, PCSource=0; IRWrite and PCWrite asserted only while `mem_ready`=1; stay until `mem_ready`, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ADD4 (branch target to ALUOut). Next: lw/sw→MEM_ADDR, R→EXEC_R, addi/ori→EXEC_I, beq→BRANCH, j→JUMP, illegal→HALT.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=2, ADD4; →MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: MemRead, IorD=1; hold until `mem_ready`, then MEM_WB. MEM_WB: RegWrite, MemtoReg=1, RegDst=0 → FETCH.
- MEM_WR: MemWrite, IorD=1; hold until `mem_ready`, then FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=0, RTYPE → R_WB: RegWrite, RegDst=1, MemtoReg=0 → FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=2, ADD4 (addi) or OR (ori) → I_WB: RegWrite, RegDst=0, MemtoReg=0 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, SUB, PCWriteCond, PCSource=1 → FETCH.
- JUMP: PCWrite, PCSource=2 → FETCH.
- HALT: all enables 0, `halted`=1; absorbing until reset.
- Unlisted outputs are 0 in every state. Opcode sampled only in DECODE/MEM_ADDR/EXEC_I.

## Timing
- Reset: `rst_n`=0 at a rising edge → state FETCH next cycle; while `rst_n`=0 every output is forced to 0 combinationally (including `halted`, MemRead).
- Reset mid-operation (e.g. during MEM_WR wait): write request drops immediately, no RF/PC write occurs, fetch restarts.
- Outputs are Moore on state except PCWrite/IRWrite in FETCH (gated by `mem_ready`).
- Zero-wait cycle counts: lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3. Each memory wait cycle adds exactly 1.
- `mem_ready` ignored outside FETCH, MEM_RD, MEM_WR.

## Structure
- Shared defines (signal_def/aluop defines): ALUCTRL_* codes, opcode constants, ALUSrcB and PCSource encodings, state encodings. ALU decoder extended to map SUB and OR codes.
- Single module, no sub-module: state register plus next-state and output case blocks.

## Test plan
- Reset with `mem_ready`=1, R-type add: outputs 0 during reset; FETCH→DECODE→EXEC_R(ALUCtrlOp=2)→R_WB(RegWrite=1, RegDst=1) → 4 cycles.
- lw with `mem_ready` low 2 cycles in MEM_RD: MemRead/IorD=1 held 3 cycles, MEM_WB MemtoReg=1, total 7 cycles.
- sw then beq: MEM_WR MemWrite=1 for one cycle; BRANCH ALUCtrlOp=1, PCWriteCond=1, PCSource=1.
- ori vs addi: EXEC_I ALUCtrlOp=3 vs 0, ALUSrcB=2; j: JUMP PCWrite=1, PCSource=2, 3 cycles.
- Opcode 111111: DECODE→HALT, `halted`=1 and all enables 0 for 20 cycles; `rst_n`=0 one cycle → FETCH, `halted`=0.
- `rst_n` pulsed during FETCH wait with `mem_ready`=0: no IRWrite/PCWrite pulse, FETCH re-entered.

Source files
------------

// File: rtl/mc_main_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main controller: FSM states,
// ALU control codes, opcodes and datapath mux selects.
package mc_main_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADDR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_EXEC_R,
    ST_R_WB,
    ST_EXEC_I,
    ST_I_WB,
    ST_BRANCH,
    ST_JUMP,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALUCTRL_ADD4  = 2'd0,
    ALUCTRL_SUB   = 2'd1,
    ALUCTRL_RTYPE = 2'd2,
    ALUCTRL_OR    = 2'd3
  } aluctrl_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/mc_main_ctrl_if.sv
// Controller <-> datapath bus: status inputs to the FSM and all selects/enables.
interface mc_main_ctrl_if;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSource;
  logic [1:0] ALUCtrlOp;
  logic       halted;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUCtrlOp, halted
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource,
           ALUCtrlOp, halted
  );
endinterface

// File: rtl/mc_main_ctrl.sv
// Main control FSM of the multi-cycle MIPS core. Moore outputs except the
// FETCH-stage PC/IR loads, which are gated by mem_ready.
module mc_main_ctrl
  import mc_main_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  mc_main_ctrl_if.master bus
);

  state_e   state_q, state_d;
  logic     pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic     mem_to_reg, reg_dst, reg_write, alu_src_a, halted;
  logic [1:0] alu_src_b, pc_source;
  aluctrl_e alu_op;

  // zero is only consumed by the datapath's conditional PC-load gate.
  logic zero_unused;
  assign zero_unused = bus.zero;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    halted        = 1'b0;
    alu_src_b     = SRCB_B;
    pc_source     = PCSRC_ALU;
    alu_op        = ALUCTRL_ADD4;
    case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (bus.opcode)
          OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
          OP_RTYPE:         state_d = ST_EXEC_R;
          OP_ADDI, OP_ORI:  state_d = ST_EXEC_I;
          OP_BEQ:           state_d = ST_BRANCH;
          OP_J:             state_d = ST_JUMP;
          default:          state_d = ST_HALT;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (bus.opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) state_d = ST_FETCH;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUCTRL_RTYPE;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = (bus.opcode == OP_ORI) ? ALUCTRL_OR : ALUCTRL_ADD4;
        state_d   = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUCTRL_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset masks every output combinationally, so a pending request drops
  // in the very cycle rst_n goes low.
  assign bus.PCWrite     = rst_n & pc_write;
  assign bus.PCWriteCond = rst_n & pc_write_cond;
  assign bus.IorD        = rst_n & iord;
  assign bus.MemRead     = rst_n & mem_read;
  assign bus.MemWrite    = rst_n & mem_write;
  assign bus.IRWrite     = rst_n & ir_write;
  assign bus.MemtoReg    = rst_n & mem_to_reg;
  assign bus.RegDst      = rst_n & reg_dst;
  assign bus.RegWrite    = rst_n & reg_write;
  assign bus.ALUSrcA     = rst_n & alu_src_a;
  assign bus.halted      = rst_n & halted;
  assign bus.ALUSrcB     = rst_n ? alu_src_b : 2'b00;
  assign bus.PCSource    = rst_n ? pc_source : 2'b00;
  assign bus.ALUCtrlOp   = rst_n ? 2'(alu_op) : 2'b00;

endmodule
